// File: rtl/hk_pll_lock_monitor.sv
// hk_pll_lock_monitor
//   Housekeeping monitor behind the flip-flop PLL phase detector. Each
//   reference window (delimited by edges of the divided reference toggle) is
//   measured in the system clock domain. A window is good when its period
//   is inside the tolerance band and the detector spent enough time in the
//   "lo asserted" and "hi deasserted" conditions. A lock FSM with
//   acquire/holdover hysteresis filters the per-window verdicts.
//
// Optional build macro: HK_PLL_LOCK_IRQ_EN adds a sticky loss interrupt.
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   cfg_en_i      monitor enable; low forces DISABLED
//   ref_tgl_i     async toggle from the reference divider
//   pll_hi_i      async detector high output
//   pll_lo_i      async detector low output
//   irq_clr_i     (HK_PLL_LOCK_IRQ_EN) clears irq_o
//   irq_o         (HK_PLL_LOCK_IRQ_EN) sticky lock-loss interrupt
//   win_valid_o   one-cycle pulse at each window close
//   win_good_o    verdict of the last closed window
//   period_o      clk_i count of the last closed window, all-ones on timeout
//   lock_o        filtered lock (LOCKED or HOLDOVER)
//   state_o       FSM state encoding
//   loss_pulse_o  one-cycle pulse on each loss of lock
//   loss_cnt_o    saturating count of lock losses
//
// State table
//   state    | meaning
//   DISABLED | monitor off, counters and run lengths cleared
//   UNLOCKED | waiting for a first good window
//   ACQUIRE  | counting consecutive good windows towards lock
//   LOCKED   | lock declared, every window good so far
//   HOLDOVER | lock still reported, counting consecutive bad windows

module hk_pll_lock_monitor #(
  parameter int NOM_CNT  = 102400,
  parameter int TOL_CNT  = 15,
  parameter int DUTY_MIN = 80000,
  parameter int ACQ_N    = 4,
  parameter int LOSS_N   = 2,
  parameter int CW       = 21
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_en_i,
  input  logic          ref_tgl_i,
  input  logic          pll_hi_i,
  input  logic          pll_lo_i,
`ifdef HK_PLL_LOCK_IRQ_EN
  input  logic          irq_clr_i,
  output logic          irq_o,
`endif
  output logic          win_valid_o,
  output logic          win_good_o,
  output logic [CW-1:0] period_o,
  output logic          lock_o,
  output logic [2:0]    state_o,
  output logic          loss_pulse_o,
  output logic [15:0]   loss_cnt_o
);

  localparam int RW = $clog2(ACQ_N + 1);
  localparam int BW = $clog2(LOSS_N + 1);

  localparam logic [CW-1:0] TMO_CNT  = CW'(2 * NOM_CNT);
  localparam logic [CW-1:0] RANGE_LO = CW'(NOM_CNT - TOL_CNT);
  localparam logic [CW-1:0] RANGE_HI = CW'(NOM_CNT + TOL_CNT);
  localparam logic [CW-1:0] DUTY_THR = CW'(DUTY_MIN);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [RW-1:0] ACQ_VAL  = RW'(ACQ_N);
  localparam logic [BW-1:0] LOSS_VAL = BW'(LOSS_N);

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_ACQUIRE  = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_HOLDOVER = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [RW-1:0]   run, run_n;
  logic [BW-1:0]   bad, bad_n;
  logic            loss;

  logic [2:0]      ref_sync;
  logic [1:0]      hi_sync;
  logic [1:0]      lo_sync;
  logic            tgl_edge;

  logic [CW-1:0]   per_cnt;
  logic [CW-1:0]   lo_cnt;
  logic [CW-1:0]   hi_cnt;
  logic            active;
  logic            timeout;
  logic            close;
  logic            in_range;
  logic            good;

  // Two flops per input for metastability; the third ref flop only serves
  // the edge detector, so ref edges and hi/lo levels stay cycle-aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_sync <= '0;
      hi_sync  <= '0;
      lo_sync  <= '0;
    end else begin
      ref_sync <= {ref_sync[1:0], ref_tgl_i};
      hi_sync  <= {hi_sync[0], pll_hi_i};
      lo_sync  <= {lo_sync[0], pll_lo_i};
    end
  end

  assign tgl_edge = ref_sync[2] ^ ref_sync[1];

  // Measurement runs only once the FSM has left DISABLED and the enable is
  // still high, so a close can never coincide with a disable.
  assign active   = cfg_en_i && (state != ST_DISABLED);
  assign timeout  = !tgl_edge && (per_cnt == TMO_CNT);
  assign close    = active && (tgl_edge || timeout);
  assign in_range = (per_cnt > RANGE_LO) && (per_cnt < RANGE_HI);
  assign good     = tgl_edge && in_range && (lo_cnt > DUTY_THR) && (hi_cnt > DUTY_THR);

  always_ff @(posedge clk_i) begin
    if (rst_i || !active) begin
      per_cnt <= '0;
      lo_cnt  <= '0;
      hi_cnt  <= '0;
    end else if (tgl_edge || timeout) begin
      per_cnt <= CW'(1);
      lo_cnt  <= CW'(1);
      hi_cnt  <= CW'(1);
    end else begin
      if (per_cnt != CNT_MAX)
        per_cnt <= per_cnt + CW'(1);
      if (lo_sync[1] && (lo_cnt != CNT_MAX))
        lo_cnt <= lo_cnt + CW'(1);
      if (!hi_sync[1] && (hi_cnt != CNT_MAX))
        hi_cnt <= hi_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_valid_o <= 1'b0;
      win_good_o  <= 1'b0;
      period_o    <= '0;
    end else begin
      win_valid_o <= close;
      if (close) begin
        win_good_o <= good;
        period_o   <= timeout ? CNT_MAX : per_cnt;
      end
    end
  end

  always_comb begin
    state_n = state;
    run_n   = run;
    bad_n   = bad;
    loss    = 1'b0;
    if (!cfg_en_i) begin
      state_n = ST_DISABLED;
      run_n   = '0;
      bad_n   = '0;
    end else begin
      case (state)
        ST_DISABLED: begin
          state_n = ST_UNLOCKED;
          run_n   = '0;
          bad_n   = '0;
        end
        ST_UNLOCKED: begin
          if (close && good) begin
            if (ACQ_VAL == RW'(1)) begin
              state_n = ST_LOCKED;
              run_n   = '0;
            end else begin
              state_n = ST_ACQUIRE;
              run_n   = RW'(1);
            end
          end
        end
        ST_ACQUIRE: begin
          if (close) begin
            if (!good) begin
              state_n = ST_UNLOCKED;
              run_n   = '0;
            end else if (run + RW'(1) == ACQ_VAL) begin
              state_n = ST_LOCKED;
              run_n   = '0;
            end else begin
              run_n = run + RW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (close && !good) begin
            if (LOSS_VAL == BW'(1)) begin
              state_n = ST_UNLOCKED;
              loss    = 1'b1;
            end else begin
              state_n = ST_HOLDOVER;
              bad_n   = BW'(1);
            end
          end
        end
        ST_HOLDOVER: begin
          if (close) begin
            if (good) begin
              state_n = ST_LOCKED;
              bad_n   = '0;
            end else if (bad + BW'(1) == LOSS_VAL) begin
              state_n = ST_UNLOCKED;
              bad_n   = '0;
              loss    = 1'b1;
            end else begin
              bad_n = bad + BW'(1);
            end
          end
        end
        default: begin
          state_n = ST_DISABLED;
          run_n   = '0;
          bad_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_DISABLED;
      run          <= '0;
      bad          <= '0;
      loss_pulse_o <= 1'b0;
      loss_cnt_o   <= '0;
    end else begin
      state        <= state_n;
      run          <= run_n;
      bad          <= bad_n;
      loss_pulse_o <= loss;
      if (loss && (loss_cnt_o != 16'hFFFF))
        loss_cnt_o <= loss_cnt_o + 16'd1;
    end
  end

  assign lock_o  = (state == ST_LOCKED) || (state == ST_HOLDOVER);
  assign state_o = state;

`ifdef HK_PLL_LOCK_IRQ_EN
  // A loss arriving together with a clear keeps the interrupt set.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      irq_o <= 1'b0;
    else if (loss_pulse_o)
      irq_o <= 1'b1;
    else if (irq_clr_i)
      irq_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_hk_pll_lock_monitor.sv
// Testbench for hk_pll_lock_monitor with scaled-down window parameters
// (100-cycle nominal window, tolerance 3, duty threshold 60).
// A window is produced by toggling ref_tgl_i, then holding pll_lo_i high for
// lo cycles and pll_hi_i low for hi cycles of the window. Each call to win()
// closes the window started by the previous call three cycles after its
// toggle, so the DUT outputs after a call describe the previous window.

module tb_hk_pll_lock_monitor;
  localparam int NOM  = 100;
  localparam int TOL  = 3;
  localparam int DUTY = 60;
  localparam int ACQ  = 4;
  localparam int LOSS = 2;
  localparam int CW   = 9;
  localparam logic [CW-1:0] ALL1 = '1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_en_i;
  logic          ref_tgl_i;
  logic          pll_hi_i;
  logic          pll_lo_i;
  logic          win_valid_o;
  logic          win_good_o;
  logic [CW-1:0] period_o;
  logic          lock_o;
  logic [2:0]    state_o;
  logic          loss_pulse_o;
  logic [15:0]   loss_cnt_o;
`ifdef HK_PLL_LOCK_IRQ_EN
  logic          irq_clr_i;
  logic          irq_o;
`endif

  int checks = 0;
  int errors = 0;
  int n_close = 0;
  int n_loss = 0;

  hk_pll_lock_monitor #(
    .NOM_CNT(NOM), .TOL_CNT(TOL), .DUTY_MIN(DUTY),
    .ACQ_N(ACQ), .LOSS_N(LOSS), .CW(CW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cfg_en_i(cfg_en_i),
    .ref_tgl_i(ref_tgl_i),
    .pll_hi_i(pll_hi_i),
    .pll_lo_i(pll_lo_i),
`ifdef HK_PLL_LOCK_IRQ_EN
    .irq_clr_i(irq_clr_i),
    .irq_o(irq_o),
`endif
    .win_valid_o(win_valid_o),
    .win_good_o(win_good_o),
    .period_o(period_o),
    .lock_o(lock_o),
    .state_o(state_o),
    .loss_pulse_o(loss_pulse_o),
    .loss_cnt_o(loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts pulse cycles, so a pulse wider than one cycle shows up as extra.
  always @(negedge clk_i) begin
    if (win_valid_o) n_close++;
    if (loss_pulse_o) n_loss++;
  end

  task automatic win(input int p, input int lo, input int hi);
    ref_tgl_i = ~ref_tgl_i;
    for (int i = 0; i < p; i++) begin
      pll_lo_i = (i < lo);
      pll_hi_i = !(i < hi);
      @(negedge clk_i);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pll_lo_i = 1'b0;
      pll_hi_i = 1'b1;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cfg_en_i = 1'b0; ref_tgl_i = 1'b0; pll_hi_i = 1'b1; pll_lo_i = 1'b0;
`ifdef HK_PLL_LOCK_IRQ_EN
    irq_clr_i = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_o); end
    checks++; if (lock_o !== 1'b0) begin errors++; $display("FAIL rst_lock got %b exp 0", lock_o); end
    checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", win_valid_o); end
    checks++; if (win_good_o !== 1'b0) begin errors++; $display("FAIL rst_good got %b exp 0", win_good_o); end
    checks++; if (period_o !== '0) begin errors++; $display("FAIL rst_period got %0d exp 0", period_o); end
    checks++; if (loss_pulse_o !== 1'b0) begin errors++; $display("FAIL rst_loss_pulse got %b exp 0", loss_pulse_o); end
    checks++; if (loss_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_loss_cnt got %0d exp 0", loss_cnt_o); end
`ifdef HK_PLL_LOCK_IRQ_EN
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq_o); end
`endif
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_acquire();
    int base;
    int es[4] = '{2, 2, 2, 3};
    base = n_close;
    cfg_en_i = 1'b1;
    win(NOM, 80, 80);
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL acq_first_state got %0d exp 1", state_o); end
    checks++; if (n_close !== base + 1) begin errors++; $display("FAIL acq_first_close got %0d exp %0d", n_close, base + 1); end
    for (int k = 0; k < 4; k++) begin
      win(NOM, 80, 80);
      checks++; if (state_o !== 3'(es[k])) begin errors++; $display("FAIL acq_state[%0d] got %0d exp %0d", k, state_o, es[k]); end
      checks++; if (win_good_o !== 1'b1) begin errors++; $display("FAIL acq_good[%0d] got %b exp 1", k, win_good_o); end
      checks++; if (period_o !== CW'(NOM)) begin errors++; $display("FAIL acq_period[%0d] got %0d exp %0d", k, period_o, NOM); end
      checks++; if (lock_o !== (k == 3)) begin errors++; $display("FAIL acq_lock[%0d] got %b exp %b", k, lock_o, (k == 3)); end
    end
    checks++; if (n_close !== base + 5) begin errors++; $display("FAIL acq_close_count got %0d exp %0d", n_close, base + 5); end
  endtask

  // Period and duty boundaries while locked; single bad windows only visit
  // HOLDOVER and come back on the next good one.
  task automatic test_qual_holdover();
    int base_l;
    int wp[11] = '{98, 97, 102, 103, 100, 100, 100, 100, 100, 100, 100};
    int wl[11] = '{80, 80, 80, 80, 80, 61, 60, 80, 80, 80, 80};
    int wh[11] = '{80, 80, 80, 80, 80, 80, 80, 61, 60, 80, 80};
    int eg[10] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    int es[10] = '{3, 4, 3, 4, 3, 3, 4, 3, 4, 3};
    base_l = n_loss;
    for (int i = 0; i < 11; i++) begin
      win(wp[i], wl[i], wh[i]);
      if (i > 0) begin
        checks++; if (win_good_o !== 1'(eg[i-1])) begin errors++; $display("FAIL qual_good[%0d] got %b exp %0d", i - 1, win_good_o, eg[i-1]); end
        checks++; if (period_o !== CW'(wp[i-1])) begin errors++; $display("FAIL qual_period[%0d] got %0d exp %0d", i - 1, period_o, wp[i-1]); end
        checks++; if (state_o !== 3'(es[i-1])) begin errors++; $display("FAIL qual_state[%0d] got %0d exp %0d", i - 1, state_o, es[i-1]); end
        checks++; if (lock_o !== 1'b1) begin errors++; $display("FAIL qual_lock[%0d] got %b exp 1", i - 1, lock_o); end
      end
    end
    checks++; if (n_loss !== base_l) begin errors++; $display("FAIL qual_no_loss got %0d exp %0d", n_loss, base_l); end
    checks++; if (loss_cnt_o !== 16'd0) begin errors++; $display("FAIL qual_loss_cnt got %0d exp 0", loss_cnt_o); end
  endtask

  // Window started 100 cycles ago; timeouts land 200 cycles apart.
  task automatic test_timeout();
    int base_c;
    int base_l;
    base_c = n_close;
    base_l = n_loss;
    idle(150);
    checks++; if (n_close !== base_c + 1) begin errors++; $display("FAIL tmo1_close got %0d exp %0d", n_close, base_c + 1); end
    checks++; if (period_o !== ALL1) begin errors++; $display("FAIL tmo1_period got %0d exp %0d", period_o, ALL1); end
    checks++; if (win_good_o !== 1'b0) begin errors++; $display("FAIL tmo1_good got %b exp 0", win_good_o); end
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL tmo1_state got %0d exp 4", state_o); end
    checks++; if (lock_o !== 1'b1) begin errors++; $display("FAIL tmo1_lock got %b exp 1", lock_o); end
    checks++; if (n_loss !== base_l) begin errors++; $display("FAIL tmo1_loss got %0d exp %0d", n_loss, base_l); end
    idle(200);
    checks++; if (n_close !== base_c + 2) begin errors++; $display("FAIL tmo2_close got %0d exp %0d", n_close, base_c + 2); end
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL tmo2_state got %0d exp 1", state_o); end
    checks++; if (lock_o !== 1'b0) begin errors++; $display("FAIL tmo2_lock got %b exp 0", lock_o); end
    checks++; if (n_loss !== base_l + 1) begin errors++; $display("FAIL tmo2_loss_pulses got %0d exp %0d", n_loss, base_l + 1); end
    checks++; if (loss_cnt_o !== 16'd1) begin errors++; $display("FAIL tmo2_loss_cnt got %0d exp 1", loss_cnt_o); end
  endtask

  task automatic test_acq_abort();
    int wl[8] = '{80, 80, 50, 80, 80, 80, 80, 80};
    int es[8] = '{1, 2, 2, 1, 2, 2, 2, 3};
    for (int i = 0; i < 8; i++) begin
      win(NOM, wl[i], 80);
      checks++; if (state_o !== 3'(es[i])) begin errors++; $display("FAIL abort_state[%0d] got %0d exp %0d", i, state_o, es[i]); end
    end
    checks++; if (lock_o !== 1'b1) begin errors++; $display("FAIL abort_lock got %b exp 1", lock_o); end
  endtask

  task automatic test_disable();
    int base_l;
    int es[5] = '{1, 2, 2, 2, 3};
    base_l = n_loss;
    cfg_en_i = 1'b0;
    @(negedge clk_i);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL dis_state got %0d exp 0", state_o); end
    checks++; if (lock_o !== 1'b0) begin errors++; $display("FAIL dis_lock got %b exp 0", lock_o); end
    checks++; if (loss_cnt_o !== 16'd1) begin errors++; $display("FAIL dis_loss_cnt got %0d exp 1", loss_cnt_o); end
    repeat (5) @(negedge clk_i);
    checks++; if (n_loss !== base_l) begin errors++; $display("FAIL dis_no_loss got %0d exp %0d", n_loss, base_l); end
    cfg_en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      win(NOM, 80, 80);
      checks++; if (state_o !== 3'(es[i])) begin errors++; $display("FAIL relock_state[%0d] got %0d exp %0d", i, state_o, es[i]); end
    end
    win(NOM, 50, 80);
    win(NOM, 50, 80);
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL dis_hold_state got %0d exp 4", state_o); end
    // This toggle closes a bad window in HOLDOVER; the enable falls in the
    // very cycle the close is evaluated.
    ref_tgl_i = ~ref_tgl_i;
    @(negedge clk_i);
    @(negedge clk_i);
    cfg_en_i = 1'b0;
    @(negedge clk_i);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL sim_state got %0d exp 0", state_o); end
    checks++; if (loss_pulse_o !== 1'b0) begin errors++; $display("FAIL sim_loss_pulse got %b exp 0", loss_pulse_o); end
    checks++; if (lock_o !== 1'b0) begin errors++; $display("FAIL sim_lock got %b exp 0", lock_o); end
    repeat (3) @(negedge clk_i);
    checks++; if (n_loss !== base_l) begin errors++; $display("FAIL sim_no_loss got %0d exp %0d", n_loss, base_l); end
    checks++; if (loss_cnt_o !== 16'd1) begin errors++; $display("FAIL sim_loss_cnt got %0d exp 1", loss_cnt_o); end
  endtask

  task automatic test_reset_mid();
    cfg_en_i = 1'b1;
    win(NOM, 80, 80);
    win(NOM, 80, 80);
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL pre_rst_state got %0d exp 2", state_o); end
    repeat (20) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL mrst_state got %0d exp 0", state_o); end
    checks++; if (win_good_o !== 1'b0) begin errors++; $display("FAIL mrst_good got %b exp 0", win_good_o); end
    checks++; if (period_o !== '0) begin errors++; $display("FAIL mrst_period got %0d exp 0", period_o); end
    checks++; if (loss_cnt_o !== 16'd0) begin errors++; $display("FAIL mrst_loss_cnt got %0d exp 0", loss_cnt_o); end
    checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", win_valid_o); end
    checks++; if (lock_o !== 1'b0) begin errors++; $display("FAIL mrst_lock got %b exp 0", lock_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

`ifdef HK_PLL_LOCK_IRQ_EN
  task automatic test_irq();
    bit found;
    for (int i = 0; i < 5; i++) win(NOM, 80, 80);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq_o); end
    win(NOM, 50, 80);
    win(NOM, 50, 80);
    win(NOM, 80, 80);
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL irq_loss1_state got %0d exp 1", state_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq_o); end
    for (int i = 0; i < 4; i++) win(NOM, 80, 80);
    win(NOM, 50, 80);
    win(NOM, 50, 80);
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL irq_hold_state got %0d exp 4", state_o); end
    ref_tgl_i = ~ref_tgl_i;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_i);
      if (loss_pulse_o) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL irq_loss2_wait got no pulse exp pulse within 10 cycles"); end
    if (found) begin
      irq_clr_i = 1'b1;
      @(negedge clk_i);
      irq_clr_i = 1'b0;
      checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b exp 1", irq_o); end
      checks++; if (loss_cnt_o !== 16'd2) begin errors++; $display("FAIL irq_loss_cnt got %0d exp 2", loss_cnt_o); end
      repeat (3) @(negedge clk_i);
      irq_clr_i = 1'b1;
      @(negedge clk_i);
      irq_clr_i = 1'b0;
      @(negedge clk_i);
      checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq_o); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_acquire();
    test_qual_holdover();
    test_timeout();
    test_acq_abort();
    test_disable();
    test_reset_mid();
`ifdef HK_PLL_LOCK_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hk_pll_lock_monitor.md
Name: hk_pll_lock_monitor

Overview:
- Housekeeping stage directly downstream of the flip-flop PLL phase detector.
- Consumes the detector's pll_hi/pll_lo outputs and a toggle bit from the reference-clock divider.
- Measures each reference window in the system clock domain and qualifies it as good or bad.
- Runs a lock FSM with acquire/holdover hysteresis and publishes filtered lock state, last measured period and a loss counter to the housekeeping register file.

Parameters:
- NOM_CNT, 102400: nominal clk_i cycles per reference half-period (125 MHz sys, 10 MHz ref, 2^13 divider).
- TOL_CNT, 15: allowed deviation; a window is in range when NOM_CNT-TOL_CNT < period < NOM_CNT+TOL_CNT.
- DUTY_MIN, 80000: minimum cycles of pll_lo asserted, and of pll_hi deasserted, within a good window.
- ACQ_N, 4: consecutive good windows needed to declare lock.
- LOSS_N, 2: consecutive bad windows in HOLDOVER that drop lock.
- CW, 21: width of window counters.

Ports:
- clk_i, in, 1: system clock.
- rst_i, in, 1: reset, synchronous, active-high.
- cfg_en_i, in, 1: monitor enable (the PLL config enable bit).
- ref_tgl_i, in, 1: asynchronous toggle from the reference-clock divider; synchronized internally.
- pll_hi_i, in, 1: detector high output; asynchronous.
- pll_lo_i, in, 1: detector low output; asynchronous.
- win_valid_o, out, 1: one-cycle pulse at each window close.
- win_good_o, out, 1: qualification of the last closed window.
- period_o, out, CW: clk_i count of the last closed window, saturating.
- lock_o, out, 1: filtered lock; high in LOCKED and HOLDOVER.
- state_o, out, 3: FSM state encoding.
- loss_pulse_o, out, 1: one-cycle pulse on any transition into UNLOCKED from LOCKED or HOLDOVER.
- loss_cnt_o, out, 16: saturating count of lock losses.

Behaviour:
- Sync:
  - ref_tgl_i, pll_hi_i and pll_lo_i each pass through a 2-FF synchronizer.
  - A third stage on ref_tgl provides edge detection.
  - An edge is any transition of the synchronized toggle.
  - Input-to-internal latency is 3 cycles.
- Window counters:
  - On an edge, per_cnt, lo_cnt and hi_cnt load 1.
  - Otherwise per_cnt increments, saturating at all-ones.
  - lo_cnt increments while sync lo=1; hi_cnt increments while sync hi=0.
- Window close:
  - A window closes on an edge, or on a timeout when per_cnt reaches 2*NOM_CNT without an edge.
  - On close, win_valid_o pulses for 1 cycle.
  - period_o latches per_cnt. On timeout it latches all-ones, and the counters restart at 1.
  - win_good = in_range(per_cnt) && lo_cnt>DUTY_MIN && hi_cnt>DUTY_MIN, evaluated on the pre-load values. Timeout windows are always bad.
  - win_good_o updates in the same cycle.
- FSM (state_o encoding):
  - DISABLED (0): entered whenever cfg_en_i=0, from any state, taking priority. Counters and good-window run length clear. Exits to UNLOCKED when cfg_en_i=1.
  - UNLOCKED (1): a good window moves to ACQUIRE with run=1.
  - ACQUIRE (2): each good window increments run; run==ACQ_N moves to LOCKED. A bad window returns to UNLOCKED with run=0.
  - LOCKED (3): a bad window moves to HOLDOVER with bad=1.
  - HOLDOVER (4): a good window returns to LOCKED with bad=0. A bad window increments bad; bad==LOSS_N moves to UNLOCKED.
- Loss accounting:
  - LOSS_N=1 means a bad window in LOCKED goes directly to UNLOCKED.
  - loss_pulse_o is registered and accompanies the state change.
  - loss_cnt_o increments on each loss and saturates at 16'hFFFF.
  - Disabling while LOCKED is not a loss.
- Simultaneous events: cfg_en_i falling in the same cycle as a window close gives DISABLED, no pulse, no count.
- Reset values (rst_i mid-operation restores these next cycle):
  - All outputs 0 except period_o=0.
  - state DISABLED, synchronizers 0.
  - loss_cnt_o is cleared only by reset.

Optional Feature:
- Macro: HK_PLL_LOCK_IRQ_EN.
- Defined:
  - Adds input irq_clr_i (1 bit) and output irq_o (1 bit).
  - irq_o sets on loss_pulse_o and stays high until an irq_clr_i cycle.
  - Set wins over a simultaneous clear.
  - Reset value 0.
- Undefined: neither port exists and there is no extra logic.

Test Plan:
- cfg_en_i=1, ref toggles every 102400 cycles, lo high 90000 and hi low 90000 per window -> lock_o=1 after 4 windows; state_o sequence 1,2,2,2,3; period_o=102400.
- Locked, then one window of 102500 cycles -> win_good_o=0, state_o=4, lock_o stays 1; next good window -> state_o=3, no loss_pulse_o.
- Locked, then ref toggle stops -> timeout after 204800 cycles with period_o=0x1FFFFF; second timeout -> state_o=1, loss_pulse_o pulses once, loss_cnt_o=1.
- ACQUIRE after 2 good windows, then a window with lo_cnt=70000 -> state_o=1; 4 further good windows required to lock.
- Locked, cfg_en_i dropped -> state_o=0, lock_o=0, loss_cnt_o unchanged; rst_i asserted mid-window -> all outputs 0 the next cycle.
- With HK_PLL_LOCK_IRQ_EN: loss sets irq_o=1; irq_clr_i in the same cycle as a second loss -> irq_o stays 1; a later clear -> irq_o=0.
